// File: rtl/surf_phy_align_v3.sv
// surf_phy_align_v3
// Automatic training engine for the SURF COUT/DOUT input PHYs. For each of
// NCHAN channels in turn it sweeps the IDELAY taps 0..31, finds the longest
// run of taps that hold a stable rotation of TRAIN_PATTERN, loads the centre
// of that eye and then bitslips until the word equals TRAIN_PATTERN exactly.
// Optional feature macro: SURF_PHY_ALIGN_MONITOR_EN (post-lock word monitor
// driving lock_lost_o; when undefined lock_lost_o is tied to 0).
module surf_phy_align_v3 #(
   parameter int         NCHAN         = 2,
   parameter int         NBITS         = 8,
   parameter logic [7:0] TRAIN_PATTERN = 8'hA9,
   parameter int         SETTLE        = 4,
   parameter int         DWELL         = 64,
   parameter int         MIN_EYE       = 4
) (
   input  logic                   sysclk_i,
   input  logic                   sysclk_rstn_i,
   input  logic                   start_i,
   input  logic [NCHAN*NBITS-1:0] data_i,
   output logic [4:0]             idelay_value_o,
   output logic [NCHAN-1:0]       idelay_load_o,
   output logic [NCHAN-1:0]       bitslip_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic [NCHAN-1:0]       fail_o,
   output logic [NCHAN-1:0]       lock_lost_o,
   input  logic [2:0]             eye_sel_i,
   output logic [4:0]             eye_center_o,
   output logic [5:0]             eye_width_o
);

   localparam logic [NBITS-1:0] PAT     = TRAIN_PATTERN[NBITS-1:0];
   localparam logic [2:0]       LAST_CH = 3'(NCHAN - 1);

   typedef enum logic [3:0] {
      ST_IDLE, ST_LOAD, ST_SETTLE, ST_DWELL, ST_NEXT_TAP, ST_CENTER,
      ST_SLIP_CHECK, ST_SLIP, ST_SLIP_WAIT, ST_NEXT_CH, ST_DONE
   } state_t;

   state_t           state_reg;
   logic [2:0]       ch_reg;
   logic [4:0]       tap_reg;
   logic [15:0]      cnt_reg;
   logic [3:0]       slips_reg;
   logic [4:0]       cur_start_reg;
   logic [5:0]       cur_len_reg;
   logic [4:0]       best_start_reg;
   logic [5:0]       best_len_reg;
   logic             good_reg;
   logic             centre_ph_reg;   // SETTLE wait belongs to the centre load
   logic [4:0]       idelay_value_reg;
   logic [NCHAN-1:0] idelay_load_reg;
   logic [NCHAN-1:0] bitslip_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [NCHAN-1:0] fail_reg;
   logic [NBITS-1:0] prev_word_reg;
   logic [4:0]       eye_center_mem [8];
   logic [5:0]       eye_width_mem [8];
   logic [4:0]       eye_center_reg;
   logic [5:0]       eye_width_reg;

   // Channel words padded to 8 entries so a 3-bit channel index always fits
   logic [NBITS-1:0] word8 [8];
   logic [7:0]       rot_ok;
   logic [NCHAN-1:0] ch_onehot;
   logic [NBITS-1:0] cur_word;
   logic             cur_rot_ok;
   logic [4:0]       run_start_c;
   logic [5:0]       run_len_c;
   logic [4:0]       centre_c;

   // True when w equals any rotation of the training pattern
   function automatic logic is_rotation(input logic [NBITS-1:0] w);
      logic [NBITS-1:0] r;
      logic             ok;
      r  = PAT;
      ok = 1'b0;
      for (int i = 0; i < NBITS; i++) begin
         if (w == r) ok = 1'b1;
         r = {r[NBITS-2:0], r[NBITS-1]};
      end
      return ok;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_word
         if (gi < NCHAN) begin : g_used
            assign word8[gi]     = data_i[gi*NBITS +: NBITS];
            assign ch_onehot[gi] = (ch_reg == 3'(gi));
         end else begin : g_unused
            assign word8[gi] = '0;
         end
         assign rot_ok[gi] = is_rotation(word8[gi]);
      end
   endgenerate

   assign cur_word   = word8[ch_reg];
   assign cur_rot_ok = rot_ok[ch_reg];

   // Run extension for a good tap, and eye centre from the best run
   always_comb begin
      run_len_c   = cur_len_reg + 6'd1;
      run_start_c = (cur_len_reg == 6'd0) ? tap_reg : cur_start_reg;
      centre_c    = best_start_reg + best_len_reg[5:1];
   end

`ifdef SURF_PHY_ALIGN_MONITOR_EN
   logic [NCHAN-1:0] locked_reg;
   logic [NCHAN-1:0] lock_lost_reg;
   assign lock_lost_o = lock_lost_reg;
`else
   assign lock_lost_o = '0;
`endif

   // Training sequencer: sweep, centre, bitslip, per channel in order
   always_ff @(posedge sysclk_i) begin
      if (!sysclk_rstn_i) begin
         state_reg        <= ST_IDLE;
         ch_reg           <= '0;
         tap_reg          <= '0;
         cnt_reg          <= '0;
         slips_reg        <= '0;
         cur_start_reg    <= '0;
         cur_len_reg      <= '0;
         best_start_reg   <= '0;
         best_len_reg     <= '0;
         good_reg         <= 1'b0;
         centre_ph_reg    <= 1'b0;
         idelay_value_reg <= '0;
         idelay_load_reg  <= '0;
         bitslip_reg      <= '0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         fail_reg         <= '0;
         for (int i = 0; i < 8; i++) begin
            eye_center_mem[i] <= '0;
            eye_width_mem[i]  <= '0;
         end
`ifdef SURF_PHY_ALIGN_MONITOR_EN
         locked_reg    <= '0;
         lock_lost_reg <= '0;
`endif
      end else begin
         idelay_load_reg <= '0;
         bitslip_reg     <= '0;
         done_reg        <= 1'b0;
`ifdef SURF_PHY_ALIGN_MONITOR_EN
         // Idle-time watch of locked, non-failed channels
         if (!busy_reg) begin
            for (int i = 0; i < NCHAN; i++) begin
               if (locked_reg[i] && !fail_reg[i] && (word8[i] != PAT))
                  lock_lost_reg[i] <= 1'b1;
            end
         end
`endif
         case (state_reg)
            ST_IDLE: begin
               if (start_i) begin
                  ch_reg         <= '0;
                  tap_reg        <= '0;
                  cnt_reg        <= '0;
                  slips_reg      <= '0;
                  cur_start_reg  <= '0;
                  cur_len_reg    <= '0;
                  best_start_reg <= '0;
                  best_len_reg   <= '0;
                  centre_ph_reg  <= 1'b0;
                  fail_reg       <= '0;
                  busy_reg       <= 1'b1;
                  state_reg      <= ST_LOAD;
`ifdef SURF_PHY_ALIGN_MONITOR_EN
                  locked_reg     <= '0;
                  lock_lost_reg  <= '0;
`endif
               end
            end
            ST_LOAD: begin
               idelay_value_reg <= tap_reg;
               idelay_load_reg  <= ch_onehot;
               cnt_reg          <= '0;
               centre_ph_reg    <= 1'b0;
               state_reg        <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (cnt_reg == 16'(SETTLE - 1)) begin
                  cnt_reg <= '0;
                  if (!centre_ph_reg) begin
                     state_reg <= ST_DWELL;
                  end else if (best_len_reg < 6'(MIN_EYE)) begin
                     fail_reg  <= fail_reg | ch_onehot;
                     state_reg <= ST_NEXT_CH;
                  end else begin
                     state_reg <= ST_SLIP_CHECK;
                  end
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_DWELL: begin
               if ((cur_word != prev_word_reg) || !cur_rot_ok) begin
                  good_reg  <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= ST_NEXT_TAP;
               end else if (cnt_reg == 16'(DWELL - 1)) begin
                  good_reg  <= 1'b1;
                  cnt_reg   <= '0;
                  state_reg <= ST_NEXT_TAP;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_NEXT_TAP: begin
               if (good_reg) begin
                  cur_start_reg <= run_start_c;
                  cur_len_reg   <= run_len_c;
                  // Strict compare keeps the first of equal-length runs
                  if (run_len_c > best_len_reg) begin
                     best_len_reg   <= run_len_c;
                     best_start_reg <= run_start_c;
                  end
               end else begin
                  cur_len_reg <= '0;
               end
               if (tap_reg != 5'd31) begin
                  tap_reg   <= tap_reg + 5'd1;
                  state_reg <= ST_LOAD;
               end else begin
                  state_reg <= ST_CENTER;
               end
            end
            ST_CENTER: begin
               eye_center_mem[ch_reg] <= centre_c;
               eye_width_mem[ch_reg]  <= best_len_reg;
               idelay_value_reg       <= centre_c;
               idelay_load_reg        <= ch_onehot;
               cnt_reg                <= '0;
               centre_ph_reg          <= 1'b1;
               state_reg              <= ST_SETTLE;
            end
            ST_SLIP_CHECK: begin
               if (cur_word == PAT) begin
`ifdef SURF_PHY_ALIGN_MONITOR_EN
                  locked_reg <= locked_reg | ch_onehot;
`endif
                  state_reg <= ST_NEXT_CH;
               end else if (slips_reg < 4'(NBITS)) begin
                  state_reg <= ST_SLIP;
               end else begin
                  fail_reg  <= fail_reg | ch_onehot;
                  state_reg <= ST_NEXT_CH;
               end
            end
            ST_SLIP: begin
               bitslip_reg <= ch_onehot;
               slips_reg   <= slips_reg + 4'd1;
               cnt_reg     <= '0;
               state_reg   <= ST_SLIP_WAIT;
            end
            ST_SLIP_WAIT: begin
               if (cnt_reg == 16'(SETTLE - 1)) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_SLIP_CHECK;
               end else begin
                  cnt_reg <= cnt_reg + 16'd1;
               end
            end
            ST_NEXT_CH: begin
               if (ch_reg != LAST_CH) begin
                  ch_reg         <= ch_reg + 3'd1;
                  tap_reg        <= '0;
                  slips_reg      <= '0;
                  cur_start_reg  <= '0;
                  cur_len_reg    <= '0;
                  best_start_reg <= '0;
                  best_len_reg   <= '0;
                  state_reg      <= ST_LOAD;
               end else begin
                  state_reg <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_reg  <= 1'b1;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Previous-cycle word of the channel under training, for stability check
   always_ff @(posedge sysclk_i) begin
      if (!sysclk_rstn_i) prev_word_reg <= '0;
      else                prev_word_reg <= cur_word;
   end

   // Registered eye readback; unused slots are never written and read 0
   always_ff @(posedge sysclk_i) begin
      if (!sysclk_rstn_i) begin
         eye_center_reg <= '0;
         eye_width_reg  <= '0;
      end else begin
         eye_center_reg <= eye_center_mem[eye_sel_i];
         eye_width_reg  <= eye_width_mem[eye_sel_i];
      end
   end

   assign idelay_value_o = idelay_value_reg;
   assign idelay_load_o  = idelay_load_reg;
   assign bitslip_o      = bitslip_reg;
   assign busy_o         = busy_reg;
   assign done_o         = done_reg;
   assign fail_o         = fail_reg;
   assign eye_center_o   = eye_center_reg;
   assign eye_width_o    = eye_width_reg;

endmodule
